spi_reg_slave: RTL and testbench

//  Parametrised SPI slave (CPOL=0) that bridges an external host to an internal register file.

---
 rtl/spi_reg_slave.sv | 109 ++++++++++
 tb/tb_spi_reg_slave.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave: CPOL=0 SPI slave, oversampled in clk, bridging a host to a register file.
// Frame = R/W bit, ADDR_W address bits, then DATA_W-bit words with optional address auto-increment.
module spi_reg_slave #(
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int RD_LAT      = 1,
   parameter bit BURST_EN    = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              frame_err,
   output logic              busy
);
   localparam int MW = ADDR_W > DATA_W ? ADDR_W : DATA_W;
   localparam int CW = $clog2(MW + 1);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, SKIP} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
   logic sclk_s, cs_s, mosi_s, sclk_q, rise, fe, rw, in_data, stop, addr_end, word_end, load;
   logic [CW-1:0] cnt;
   logic [ADDR_W-1:0] addr, addr_nxt;
   logic [DATA_W-1:0] sh, sh_nxt;
   logic [3:0] dly_q;
   logic [4:0] dly;
   assign sclk_s   = sclk_sr[SYNC_STAGES-1];
   assign cs_s     = cs_sr[SYNC_STAGES-1];
   assign mosi_s   = mosi_sr[SYNC_STAGES-1];
   assign rise     = sclk_s & ~sclk_q;
   // a fall coinciding with cs_n rise is dropped so the abort rule sees the partial word
   assign fe       = ~sclk_s & sclk_q & ~cs_s;
   assign in_data  = state_q == WDATA || state_q == RDATA;
   assign stop     = cs_s && state_q != IDLE;
   assign addr_end = fe && state_q == ADDR && cnt == CW'(ADDR_W - 1);
   assign word_end = fe && in_data && cnt == CW'(DATA_W - 1);
   assign addr_nxt = {addr[ADDR_W-2:0], mosi_s};
   assign sh_nxt   = {sh[DATA_W-2:0], mosi_s};
   assign dly      = {dly_q, rd_req};
   assign load     = |(dly & (5'd1 << RD_LAT));
   assign busy     = ~cs_s;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else state_q <= state_d;
   always_comb begin
      state_d = state_q;
      if (cs_s) state_d = IDLE;
      else if (state_q == IDLE) state_d = CMD;
      else if (fe && state_q == CMD) state_d = ADDR;
      else if (addr_end) state_d = rw ? RDATA : WDATA;
      else if (word_end && !BURST_EN) state_d = SKIP;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sclk_sr   <= '0;
         cs_sr     <= '1;
         mosi_sr   <= '0;
         sclk_q    <= 1'b0;
         dly_q     <= '0;
         rw        <= 1'b0;
         cnt       <= '0;
         addr      <= '0;
         sh        <= '0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_req    <= 1'b0;
         rd_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_q    <= sclk_s;
         dly_q     <= dly[3:0];
         wr_en     <= word_end && state_q == WDATA;
         rd_req    <= (addr_end && rw) || (word_end && state_q == RDATA && BURST_EN);
         frame_err <= stop && (state_q == CMD || state_q == ADDR || (in_data && |cnt));
         cnt       <= (cs_s || addr_end || word_end || state_q == CMD) ? '0 :
                      (fe && (state_q == ADDR || in_data)) ? cnt + 1'b1 : cnt;
         if (fe && state_q == CMD) rw <= mosi_s;
         if (fe && state_q == ADDR) addr <= addr_nxt;
         if (addr_end) rd_addr <= addr_nxt;
         if (word_end) begin
            addr    <= addr + 1'b1;
            rd_addr <= addr + 1'b1;
         end
         if (word_end && state_q == WDATA) begin
            wr_addr <= addr;
            wr_data <= sh_nxt;
         end
         sh      <= load ? rd_data : (fe && state_q == WDATA) ? sh_nxt :
                    (rise && state_q == RDATA) ? {sh[DATA_W-2:0], 1'b0} : sh;
         miso    <= (cs_s || state_q != RDATA) ? 1'b0 : rise ? sh[DATA_W-1] : miso;
         miso_oe <= (cs_s || state_q != RDATA) ? 1'b0 : rise | miso_oe;
      end
endmodule

// File: tb/tb_spi_reg_slave.sv
// tb_spi_reg_slave: scoreboard bench for two spi_reg_slave configurations sharing sclk/mosi.
module tb_spi_reg_slave;
   localparam int H = 12;
   typedef struct {int k; int a; int v;} ev_t;
   logic clk = 1'b0, rst_n, sclk, mosi, cs0, cs1;
   logic miso0, miso_oe0, wr_en0, rd_req0, frame_err0, busy0;
   logic [6:0] wr_addr0, rd_addr0;
   logic [7:0] wr_data0, rd_data0;
   logic miso1, miso_oe1, wr_en1, rd_req1, frame_err1, busy1;
   logic [4:0] wr_addr1, rd_addr1;
   logic [15:0] wr_data1, rd_data1;
   logic [7:0] mem0 [128];
   logic [15:0] mem1 [32];
   logic p0;
   logic [6:0] a0;
   logic [2:0] p1;
   logic [4:0] a1 [3];
   ev_t sq0[$], sq1[$];
   logic [15:0] dq0[$], dq1[$], rxq0[$], rxq1[$];
   int checks = 0, failures = 0, cur = 0;
   logic smp;
   always #5 clk = ~clk;
   spi_reg_slave u0 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs0), .mosi(mosi), .miso(miso0),
      .miso_oe(miso_oe0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
      .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_data(rd_data0), .frame_err(frame_err0), .busy(busy0)
   );
   spi_reg_slave #(.ADDR_W(5), .DATA_W(16), .RD_LAT(3)) u1 (
      .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs1), .mosi(mosi), .miso(miso1),
      .miso_oe(miso_oe1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
      .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1), .frame_err(frame_err1), .busy(busy1)
   );
   // register-file model: data is valid only in the exact RD_LAT-th cycle after rd_req
   always @(posedge clk) begin
      p0 <= rd_req0;
      a0 <= rd_addr0;
      p1 <= {p1[1:0], rd_req1};
      a1[0] <= rd_addr1;
      a1[1] <= a1[0];
      a1[2] <= a1[1];
   end
   assign rd_data0 = p0 ? mem0[a0] : 8'h00;
   assign rd_data1 = p1[2] ? mem1[a1[2]] : 16'h0000;
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic pop_s(input int d, input int k, input int a, input int v);
      ev_t e;
      if ((d == 0 ? sq0.size() : sq1.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL strobe%0d: got unexpected kind=%0d addr=%0h data=%0h expected none", d, k, a, v);
      end else begin
         e = d == 0 ? sq0.pop_front() : sq1.pop_front();
         chk($sformatf("strobe%0d", d), {8'(k), 24'(a), 32'(v)}, {8'(e.k), 24'(e.a), 32'(e.v)});
      end
   endtask
   task automatic pop_d(input int d, input logic [15:0] w);
      if ((d == 0 ? dq0.size() : dq1.size()) == 0) begin
         checks++;
         failures++;
         $display("FAIL miso_word%0d: got unexpected %0h expected none", d, w);
      end else chk($sformatf("miso_word%0d", d), 64'(w), 64'(d == 0 ? dq0.pop_front() : dq1.pop_front()));
   endtask
   // monitor: kinds 1=write, 2=read request, 3=frame error
   always @(negedge clk) begin
      if (wr_en0) pop_s(0, 1, 32'(wr_addr0), 32'(wr_data0));
      if (rd_req0) pop_s(0, 2, 32'(rd_addr0), 0);
      if (frame_err0) pop_s(0, 3, 0, 0);
      if (wr_en1) pop_s(1, 1, 32'(wr_addr1), 32'(wr_data1));
      if (rd_req1) pop_s(1, 2, 32'(rd_addr1), 0);
      if (frame_err1) pop_s(1, 3, 0, 0);
      while (rxq0.size() > 0) pop_d(0, rxq0.pop_front());
      while (rxq1.size() > 0) pop_d(1, rxq1.pop_front());
   end
   task automatic exp_s(input int d, input int k, input int a, input int v);
      ev_t e;
      e = '{k, a, v};
      if (d == 0) sq0.push_back(e);
      else sq1.push_back(e);
   endtask
   task automatic sbit(input logic b);
      mosi = b;
      repeat (H) @(posedge clk);
      sclk = 1'b1;
      repeat (H) @(posedge clk);
      sclk = 1'b0;
      repeat (2) @(posedge clk);
      smp = cur == 0 ? miso0 : miso1;
      repeat (H - 2) @(posedge clk);
   endtask
   task automatic xfer(input int d, input logic [63:0] v, input int n, input int hdr, input int dw,
                       input bit rd, input bit close);
      logic [15:0] acc;
      acc = '0;
      cur = d;
      if (d == 0) cs0 = 1'b0;
      else cs1 = 1'b0;
      repeat (H) @(posedge clk);
      for (int i = n - 1; i >= 0; i--) begin
         sbit(v[i]);
         if (rd && n - 1 - i >= hdr) begin
            acc = {acc[14:0], smp};
            if ((n - i - hdr) % dw == 0) begin
               chk("miso_oe_in_read", 64'(d == 0 ? miso_oe0 : miso_oe1), 64'd1);
               if (d == 0) rxq0.push_back(acc);
               else rxq1.push_back(acc);
               acc = '0;
            end
         end
      end
      if (close) begin
         repeat (H) @(posedge clk);
         cs0 = 1'b1;
         cs1 = 1'b1;
         repeat (3 * H) @(posedge clk);
      end
   endtask
   initial begin
      for (int i = 0; i < 128; i++) mem0[i] = 8'(i * 3);
      for (int i = 0; i < 32; i++) mem1[i] = 16'(i * 257);
      mem0[7] = 8'hA5;
      mem1[31] = 16'hBEEF;
      mem1[0] = 16'h1234;
      rst_n = 1'b0;
      sclk = 1'b0;
      mosi = 1'b0;
      cs0 = 1'b1;
      cs1 = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", {wr_en0, rd_req0, frame_err0, miso0, miso_oe0, busy0,
                        wr_en1, rd_req1, frame_err1, miso1, miso_oe1, busy1}, 64'd0);
      chk("reset_bus", {wr_addr0, wr_data0, rd_addr0, wr_addr1, wr_data1, rd_addr1}, 64'd0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      exp_s(0, 1, 'h01, 'h3C);
      xfer(0, {1'b0, 7'h01, 8'h3C}, 16, 8, 8, 0, 1);
      exp_s(0, 2, 'h07, 0);
      exp_s(0, 2, 'h08, 0);
      dq0.push_back(16'h00A5);
      xfer(0, {1'b1, 7'h07, 8'h00}, 16, 8, 8, 1, 1);
      chk("miso_oe_after_read", 64'(miso_oe0), 64'd0);
      exp_s(0, 1, 'h7F, 'h11);
      exp_s(0, 1, 'h00, 'h22);
      xfer(0, {1'b0, 7'h7F, 8'h11, 8'h22}, 24, 8, 8, 0, 1);
      exp_s(0, 3, 0, 0);
      xfer(0, {1'b0, 7'h01, 2'b11}, 10, 8, 8, 0, 1);
      chk("idle_after_abort", {busy0, miso_oe0, miso0}, 64'd0);
      exp_s(0, 3, 0, 0);
      xfer(0, 64'd0, 0, 8, 8, 0, 1);
      exp_s(0, 3, 0, 0);
      xfer(0, 64'b0101, 4, 8, 8, 0, 1);
      exp_s(0, 2, 'h07, 0);
      xfer(0, {1'b1, 7'h07, 4'h0}, 12, 8, 8, 1, 0);
      chk("miso_oe_mid_read", 64'(miso_oe0), 64'd1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("miso_in_reset", {miso0, miso_oe0}, 64'd0);
      cs0 = 1'b1;
      repeat (H) @(posedge clk);
      rst_n = 1'b1;
      repeat (H) @(posedge clk);
      exp_s(0, 1, 'h05, 'h5A);
      xfer(0, {1'b0, 7'h05, 8'h5A}, 16, 8, 8, 0, 1);
      exp_s(1, 2, 'h1F, 0);
      exp_s(1, 2, 'h00, 0);
      exp_s(1, 2, 'h01, 0);
      dq1.push_back(16'hBEEF);
      dq1.push_back(16'h1234);
      xfer(1, {1'b1, 5'h1F, 32'h0}, 38, 6, 16, 1, 1);
      repeat (20) @(posedge clk);
      chk("strobes_left0", 64'(sq0.size()), 64'd0);
      chk("strobes_left1", 64'(sq1.size()), 64'd0);
      chk("words_left", 64'(dq0.size() + dq1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
